// File: rtl/lpc_dispatch_pkg.sv
// Shared types and constants for the LPC peripheral dispatcher and its decoder.
package lpc_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Default byte returned when no target answers a read.
  localparam logic [7:0] UNMAPPED_RD_DEF = 8'hFF;

  // Width of a target index; kept at least 1 bit so a single-target build still has a vector.
  function automatic int tgt_idx_w(input int num_tgt);
    return (num_tgt > 1) ? $clog2(num_tgt) : 1;
  endfunction

endpackage

// File: rtl/lpc_periph_dispatch_if.sv
// Target-side register bus: one-hot strobe with latched address/data, per-target ack and read data.
interface lpc_periph_dispatch_if #(
  parameter int NUM_TGT = 4
);
  logic [NUM_TGT-1:0]   tgt_req_o;
  logic                 tgt_we_o;
  logic [15:0]          tgt_addr_o;
  logic [7:0]           tgt_wdata_o;
  logic [NUM_TGT-1:0]   tgt_ack_i;
  logic [8*NUM_TGT-1:0] tgt_rdata_i;

  modport master (
    output tgt_req_o, tgt_we_o, tgt_addr_o, tgt_wdata_o,
    input  tgt_ack_i, tgt_rdata_i
  );

  modport slave (
    input  tgt_req_o, tgt_we_o, tgt_addr_o, tgt_wdata_o,
    output tgt_ack_i, tgt_rdata_i
  );
endinterface

// File: rtl/lpc_addr_decode.sv
// Combinational base/mask address decoder; the lowest-numbered matching window wins.
module lpc_addr_decode
  import lpc_dispatch_pkg::*;
#(
  parameter int                  NUM_TGT  = 4,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE = {16'h0800, 16'h0400, 16'h0060, 16'h0080},
  parameter logic [16*NUM_TGT-1:0] TGT_MASK = {16'hF800, 16'hFF00, 16'hFFF0, 16'hFFFF},
  parameter int                  IDX_W    = tgt_idx_w(NUM_TGT)
) (
  input  logic [15:0]        addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_TGT-1:0] onehot
);

  // Scan from the top down so a lower index overrides any higher overlapping window.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = NUM_TGT - 1; k >= 0; k--) begin
      if ((addr & TGT_MASK[16*k +: 16]) == (TGT_BASE[16*k +: 16] & TGT_MASK[16*k +: 16])) begin
        hit = 1'b1;
        idx = k[IDX_W-1:0];
      end
    end
    if (hit) onehot = NUM_TGT'(1) << idx;
  end

endmodule

// File: rtl/lpc_periph_dispatch.sv
// Routes lpc_periph read/write cycles to one of NUM_TGT register targets and completes
// the LPC handshake; unmapped or unanswered accesses finish with a fixed response.
module lpc_periph_dispatch
  import lpc_dispatch_pkg::*;
#(
  parameter int                    NUM_TGT     = 4,
  parameter logic [16*NUM_TGT-1:0] TGT_BASE    = {16'h0800, 16'h0400, 16'h0060, 16'h0080},
  parameter logic [16*NUM_TGT-1:0] TGT_MASK    = {16'hF800, 16'hFF00, 16'hFFF0, 16'hFFFF},
  parameter int                    TIMEOUT_CYC = 32,
  parameter logic [7:0]            UNMAPPED_RD = UNMAPPED_RD_DEF
) (
  input  logic                  clk_i,
  input  logic                  LRESET,
  input  logic [15:0]           lpc_addr_i,
  input  logic [7:0]            lpc_data_i,
  output logic [7:0]            lpc_data_o,
  input  logic                  lpc_data_wr_i,
  output logic                  lpc_wr_done_o,
  input  logic                  lpc_data_req_i,
  output logic                  lpc_data_rd_o,
  lpc_periph_dispatch_if.master tgt,
  output logic                  err_unmapped_o,
  output logic                  err_timeout_o,
  input  logic                  err_clr_i
);

  localparam int IDX_W = tgt_idx_w(NUM_TGT);

  state_t               state, state_nxt;
  logic                 dec_hit;
  logic [IDX_W-1:0]     dec_idx;
  logic [NUM_TGT-1:0]   dec_oh;
  logic [NUM_TGT-1:0]   sel_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic                 we_q;
  logic [15:0]          addr_q;
  logic [7:0]           wdata_q;
  logic [7:0]           rdata_q;
  logic [7:0]           cnt;
  logic                 cyc_req, ack_hit, tmo, unmapped_set, tmo_set;
  logic [7:0]           sel_rdata;

  lpc_addr_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr   (lpc_addr_i),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_oh)
  );

  assign cyc_req      = lpc_data_wr_i | lpc_data_req_i;
  assign ack_hit      = |(tgt.tgt_ack_i & sel_oh);
  assign tmo          = (cnt == 8'(TIMEOUT_CYC - 1));
  assign sel_rdata    = tgt.tgt_rdata_i[8*sel_idx +: 8];
  assign unmapped_set = (state == IDLE) && cyc_req && !dec_hit;
  assign tmo_set      = (state == ACCESS) && !ack_hit && tmo;

  // State register.
  always_ff @(posedge clk_i or negedge LRESET) begin
    if (!LRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: DONE is held until the host drops both request lines.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cyc_req) state_nxt = dec_hit ? ACCESS : DONE;
      ACCESS:  if (ack_hit || tmo) state_nxt = DONE;
      DONE:    if (!cyc_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the current state.
  always_comb begin
    tgt.tgt_req_o = (state == ACCESS) ? sel_oh : '0;
    lpc_wr_done_o = (state == DONE) && we_q;
    lpc_data_rd_o = (state == DONE) && !we_q;
  end

  // Cycle capture, timeout counter and read-data return register.
  always_ff @(posedge clk_i or negedge LRESET) begin
    if (!LRESET) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_oh  <= '0;
      sel_idx <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else if (state == IDLE) begin
      if (cyc_req) begin
        we_q    <= lpc_data_wr_i;
        addr_q  <= lpc_addr_i;
        wdata_q <= lpc_data_i;
        sel_oh  <= dec_oh;
        sel_idx <= dec_idx;
        cnt     <= '0;
        if (!dec_hit && !lpc_data_wr_i) rdata_q <= UNMAPPED_RD;
      end
    end else if (state == ACCESS) begin
      if (ack_hit) begin
        if (!we_q) rdata_q <= sel_rdata;
      end else if (tmo) begin
        if (!we_q) rdata_q <= UNMAPPED_RD;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge LRESET) begin
    if (!LRESET) begin
      err_unmapped_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      if (unmapped_set)   err_unmapped_o <= 1'b1;
      else if (err_clr_i) err_unmapped_o <= 1'b0;
      if (tmo_set)        err_timeout_o  <= 1'b1;
      else if (err_clr_i) err_timeout_o  <= 1'b0;
    end
  end

  assign tgt.tgt_we_o    = we_q;
  assign tgt.tgt_addr_o  = addr_q;
  assign tgt.tgt_wdata_o = wdata_q;
  assign lpc_data_o      = rdata_q;

endmodule

// File: tb/tb_lpc_periph_dispatch.sv
// Directed bench for lpc_periph_dispatch with a delay-configurable target model.
module tb_lpc_periph_dispatch;

  logic        clk_i = 1'b0;
  logic        LRESET = 1'b0;
  logic [15:0] lpc_addr_i = '0;
  logic [7:0]  lpc_data_i = '0;
  logic        lpc_data_wr_i = 1'b0;
  logic        lpc_data_req_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [7:0]  lpc_data_o, lpc_data_o2;
  logic        lpc_wr_done_o, lpc_data_rd_o, lpc_wr_done_o2, lpc_data_rd_o2;
  logic        err_unmapped_o, err_timeout_o, err_unmapped_o2, err_timeout_o2;

  int checks = 0;
  int errors = 0;
  int n;

  // Target model configuration: ack delay in req-high cycles (0 = never acks) and read data.
  logic [7:0]  dly [4];
  logic [31:0] rdata_cfg = '0;
  logic [3:0]  ack_m = '0;
  int          cnt_m [4];

  lpc_periph_dispatch_if #(.NUM_TGT(4)) tif ();
  lpc_periph_dispatch_if #(.NUM_TGT(4)) tif2 ();

  assign tif.tgt_ack_i    = ack_m;
  assign tif.tgt_rdata_i  = rdata_cfg;
  assign tif2.tgt_ack_i   = tif2.tgt_req_o;
  assign tif2.tgt_rdata_i = 32'h44332211;

  lpc_periph_dispatch dut (
    .clk_i (clk_i), .LRESET (LRESET),
    .lpc_addr_i (lpc_addr_i), .lpc_data_i (lpc_data_i), .lpc_data_o (lpc_data_o),
    .lpc_data_wr_i (lpc_data_wr_i), .lpc_wr_done_o (lpc_wr_done_o),
    .lpc_data_req_i (lpc_data_req_i), .lpc_data_rd_o (lpc_data_rd_o),
    .tgt (tif.master),
    .err_unmapped_o (err_unmapped_o), .err_timeout_o (err_timeout_o), .err_clr_i (err_clr_i)
  );

  lpc_periph_dispatch #(
    .TGT_BASE ({16'h0800, 16'h0400, 16'h0080, 16'h0080}),
    .TGT_MASK ({16'hF800, 16'hFF00, 16'hFFF0, 16'hFFFF})
  ) dut2 (
    .clk_i (clk_i), .LRESET (LRESET),
    .lpc_addr_i (lpc_addr_i), .lpc_data_i (lpc_data_i), .lpc_data_o (lpc_data_o2),
    .lpc_data_wr_i (lpc_data_wr_i), .lpc_wr_done_o (lpc_wr_done_o2),
    .lpc_data_req_i (lpc_data_req_i), .lpc_data_rd_o (lpc_data_rd_o2),
    .tgt (tif2.master),
    .err_unmapped_o (err_unmapped_o2), .err_timeout_o (err_timeout_o2), .err_clr_i (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Target model: raise ack so it is seen on the dly-th clock edge with req high.
  always @(posedge clk_i) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      if (tif.tgt_req_o[k] && !ack_m[k]) begin
        if (dly[k] != 8'd0 && cnt_m[k] == int'(dly[k]) - 1) ack_m[k] = 1'b1;
        else cnt_m[k] = cnt_m[k] + 1;
      end else begin
        ack_m[k] = 1'b0;
        cnt_m[k] = 0;
      end
    end
  end

  // Count negedges with the expected strobe until a handshake output rises, within a bound.
  task automatic wait_done(input int maxc, input logic [3:0] expreq, output int reqcyc);
    bit done = 0;
    reqcyc = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk_i);
      if (lpc_wr_done_o || lpc_data_rd_o) done = 1;
      else if (tif.tgt_req_o === expreq) reqcyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: no handshake within %0d cycles (req=%b)", maxc, tif.tgt_req_o);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({tif.tgt_req_o, tif.tgt_we_o, tif.tgt_addr_o, tif.tgt_wdata_o, lpc_data_o,
         lpc_wr_done_o, lpc_data_rd_o, err_unmapped_o, err_timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b data=%h done=%b rd=%b, want all zero",
               tif.tgt_req_o, lpc_data_o, lpc_wr_done_o, lpc_data_rd_o);
    end
    repeat (2) @(negedge clk_i);
    LRESET = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({tif.tgt_req_o, lpc_wr_done_o, lpc_data_rd_o} !== '0) begin
      errors++;
      $display("FAIL reset_release: req=%b done=%b rd=%b want 0", tif.tgt_req_o, lpc_wr_done_o, lpc_data_rd_o);
    end
  endtask

  task automatic test_write;
    dly[0] = 8'd1;
    lpc_addr_i = 16'h0080; lpc_data_i = 8'h5A; lpc_data_wr_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (tif.tgt_req_o !== 4'b0001 || tif.tgt_we_o !== 1'b1 || tif.tgt_wdata_o !== 8'h5A ||
        tif.tgt_addr_o !== 16'h0080 || lpc_wr_done_o !== 1'b0) begin
      errors++;
      $display("FAIL write_strobe: req=%b we=%b wdata=%h addr=%h done=%b want 0001 1 5a 0080 0",
               tif.tgt_req_o, tif.tgt_we_o, tif.tgt_wdata_o, tif.tgt_addr_o, lpc_wr_done_o);
    end
    @(negedge clk_i);
    checks++;
    if (lpc_wr_done_o !== 1'b1 || tif.tgt_req_o !== 4'b0000) begin
      errors++;
      $display("FAIL write_done: done=%b req=%b want 1 0000", lpc_wr_done_o, tif.tgt_req_o);
    end
    lpc_data_wr_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (lpc_wr_done_o !== 1'b0) begin
      errors++;
      $display("FAIL write_done_clear: done=%b want 0", lpc_wr_done_o);
    end
  endtask

  task automatic test_read_slow;
    dly[1] = 8'd10; rdata_cfg[15:8] = 8'hBB;
    lpc_addr_i = 16'h0065; lpc_data_req_i = 1'b1;
    wait_done(40, 4'b0010, n);
    checks++;
    if (n != 10 || lpc_data_o !== 8'hBB || lpc_data_rd_o !== 1'b1) begin
      errors++;
      $display("FAIL read_slow: req_cycles=%0d data=%h rd=%b want 10 bb 1", n, lpc_data_o, lpc_data_rd_o);
    end
    @(negedge clk_i);
    checks++;
    if (lpc_data_rd_o !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: rd=%b want 1", lpc_data_rd_o);
    end
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (lpc_data_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL read_release: rd=%b want 0", lpc_data_rd_o);
    end
  endtask

  task automatic test_unmapped;
    lpc_addr_i = 16'h9696; lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (lpc_data_rd_o !== 1'b1 || lpc_data_o !== 8'hFF || err_unmapped_o !== 1'b1 ||
        tif.tgt_req_o !== 4'b0000) begin
      errors++;
      $display("FAIL unmapped_read: rd=%b data=%h err=%b req=%b want 1 ff 1 0000",
               lpc_data_rd_o, lpc_data_o, err_unmapped_o, tif.tgt_req_o);
    end
    lpc_data_req_i = 1'b0; err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checks++;
    if (err_unmapped_o !== 1'b0 || lpc_data_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_clear: err=%b rd=%b want 0 0", err_unmapped_o, lpc_data_rd_o);
    end
  endtask

  task automatic test_timeout;
    dly[2] = 8'd0;
    lpc_addr_i = 16'h0410; lpc_data_i = 8'h77; lpc_data_wr_i = 1'b1;
    wait_done(60, 4'b0100, n);
    checks++;
    if (n != 32 || lpc_wr_done_o !== 1'b1 || err_timeout_o !== 1'b1 || tif.tgt_req_o !== 4'b0000) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d done=%b err=%b req=%b want 32 1 1 0000",
               n, lpc_wr_done_o, err_timeout_o, tif.tgt_req_o);
    end
    lpc_data_wr_i = 1'b0;
    @(negedge clk_i);
    dly[0] = 8'd1;
    lpc_addr_i = 16'h0080; lpc_data_i = 8'h33; lpc_data_wr_i = 1'b1;
    wait_done(10, 4'b0001, n);
    checks++;
    if (n != 1 || lpc_wr_done_o !== 1'b1 || tif.tgt_wdata_o !== 8'h33 || err_timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL after_timeout: req_cycles=%0d done=%b wdata=%h err=%b want 1 1 33 1",
               n, lpc_wr_done_o, tif.tgt_wdata_o, err_timeout_o);
    end
    lpc_data_wr_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_overlap;
    dly[0] = 8'd1; rdata_cfg[7:0] = 8'h5C;
    lpc_addr_i = 16'h0080; lpc_data_req_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (tif2.tgt_req_o !== 4'b0001) begin
      errors++;
      $display("FAIL overlap_select: req=%b want 0001", tif2.tgt_req_o);
    end
    @(negedge clk_i);
    checks++;
    if (lpc_data_o2 !== 8'h11 || lpc_data_rd_o2 !== 1'b1 || lpc_data_o !== 8'h5C || lpc_data_rd_o !== 1'b1) begin
      errors++;
      $display("FAIL overlap_data: data2=%h rd2=%b data=%h rd=%b want 11 1 5c 1",
               lpc_data_o2, lpc_data_rd_o2, lpc_data_o, lpc_data_rd_o);
    end
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid;
    dly[3] = 8'd0;
    lpc_addr_i = 16'h0800; lpc_data_req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (tif.tgt_req_o !== 4'b1000) begin
      errors++;
      $display("FAIL mid_access_req: req=%b want 1000", tif.tgt_req_o);
    end
    #2;
    LRESET = 1'b0; lpc_data_req_i = 1'b0;
    #1;
    checks++;
    if ({tif.tgt_req_o, tif.tgt_we_o, tif.tgt_addr_o, lpc_data_o, lpc_data_rd_o,
         lpc_wr_done_o, err_timeout_o, err_unmapped_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%b addr=%h data=%h rd=%b errt=%b want all zero",
               tif.tgt_req_o, tif.tgt_addr_o, lpc_data_o, lpc_data_rd_o, err_timeout_o);
    end
    @(negedge clk_i);
    LRESET = 1'b1;
    dly[3] = 8'd3; rdata_cfg[31:24] = 8'hC3;
    @(negedge clk_i);
    lpc_addr_i = 16'h0800; lpc_data_req_i = 1'b1;
    wait_done(20, 4'b1000, n);
    checks++;
    if (n != 3 || lpc_data_o !== 8'hC3 || lpc_data_rd_o !== 1'b1) begin
      errors++;
      $display("FAIL read_after_reset: req_cycles=%0d data=%h rd=%b want 3 c3 1", n, lpc_data_o, lpc_data_rd_o);
    end
    lpc_data_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      dly[k]   = 8'd1;
      cnt_m[k] = 0;
    end
    test_reset;
    test_write;
    test_read_slow;
    test_unmapped;
    test_timeout;
    test_overlap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
